// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts LATENCY wait
// states, performs byte-lane writes and returns sign/zero-extended loads.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_req,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic [2:0]  i_mem_funct3,
  input  logic        i_mem_read_write,
  output logic        o_mem_ack,
  output logic [31:0] o_mem_data,
  output logic        o_mem_err,
  output logic        o_busy
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, data_q;
  logic [2:0]  f3_q;
  logic        rw_q;
  logic        ack_q, err_q, busy_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] op_addr, op_data, offset, rword, shifted, load_val, wdata;
  logic [2:0]  op_f3;
  logic        op_rw, fault, resp_go, we;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [AW-1:0] widx;

  // With zero latency the response is formed on the accepting edge, so the
  // operands come straight from the inputs instead of the capture registers.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_addr = i_mem_addr;
      op_data = i_mem_data;
      op_f3   = i_mem_funct3;
      op_rw   = i_mem_read_write;
    end else begin
      op_addr = addr_q;
      op_data = data_q;
      op_f3   = f3_q;
      op_rw   = rw_q;
    end
  end

  assign resp_go = ((state_q == S_IDLE) && i_mem_req && (LATENCY == 0)) ||
                   ((state_q == S_WAIT) && (cnt_q == '0));

  assign offset = op_addr - BASE_ADDR;
  assign lane   = offset[1:0];
  assign widx   = offset[AW+1:2];

  always_comb begin
    fault = |offset[31:AW+2];
    if (op_rw) begin
      if (op_f3 >= 3'd3) fault = 1'b1;
    end else if ((op_f3 == 3'd3) || (op_f3 == 3'd6) || (op_f3 == 3'd7)) begin
      fault = 1'b1;
    end
    if ((op_f3[1:0] == 2'd1) && lane[0]) fault = 1'b1;
    if ((op_f3[1:0] == 2'd2) && (lane != 2'd0)) fault = 1'b1;
  end

  assign rword   = mem[widx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    case (op_f3)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd4:    load_val = {24'd0, shifted[7:0]};
      3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'd5:    load_val = {16'd0, shifted[15:0]};
      3'd2:    load_val = rword;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    case (op_f3)
      3'd0:    begin be = 4'b0001 << lane; wdata = {4{op_data[7:0]}};  end
      3'd1:    begin be = 4'b0011 << lane; wdata = {2{op_data[15:0]}}; end
      default: begin be = 4'b1111;         wdata = op_data;            end
    endcase
  end

  assign we = resp_go && op_rw && !fault && i_rst_n;

  always_ff @(posedge i_clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_mem_req) begin
            addr_q <= i_mem_addr;
            data_q <= i_mem_data;
            f3_q   <= i_mem_funct3;
            rw_q   <= i_mem_read_write;
            busy_q <= 1'b1;
            if (LATENCY == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_RESP;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      if (resp_go) begin
        ack_q   <= 1'b1;
        err_q   <= fault;
        rdata_q <= (fault || op_rw) ? '0 : load_val;
      end
    end
  end

  assign o_mem_ack  = ack_q;
  assign o_mem_data = rdata_q;
  assign o_mem_err  = err_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of load/store vectors on a LATENCY=2
// instance, plus reset-during-wait and zero-latency handshake sequences.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_req, a_rw, a_ack, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [2:0]  a_f3;
  logic        b_req, b_rw, b_ack, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [2:0]  b_f3;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(a_req), .i_mem_addr(a_addr),
    .i_mem_data(a_wdata), .i_mem_funct3(a_f3), .i_mem_read_write(a_rw),
    .o_mem_ack(a_ack), .o_mem_data(a_rdata), .o_mem_err(a_err), .o_busy(a_busy)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(b_req), .i_mem_addr(b_addr),
    .i_mem_data(b_wdata), .i_mem_funct3(b_f3), .i_mem_read_write(b_rw),
    .o_mem_ack(b_ack), .o_mem_data(b_rdata), .o_mem_err(b_err), .o_busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  int b_acks = 0;

  typedef struct {
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        err;
    logic        cd;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        cd;
  } exp_t;

  vec_t tbl[20];
  exp_t sbq[$];

  always @(posedge clk) if (b_ack) b_acks++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request on instance A, scramble the inputs while it waits,
  // and compare the ack against the scoreboard entry pushed at drive time.
  task automatic txn_a(input vec_t v, input string name);
    int   lat;
    logic got;
    exp_t x;
    @(negedge clk);
    a_req = 1'b1; a_rw = v.rw; a_f3 = v.f3; a_addr = v.addr; a_wdata = v.data;
    sbq.push_back('{v.exp, v.err, v.cd});
    @(posedge clk);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (a_ack) got = 1'b1;
      else if (lat == 1) begin
        chk({name, " busy"}, 32'(a_busy), 32'd1);
        a_addr = ~v.addr; a_wdata = ~v.data; a_f3 = 3'd7; a_rw = ~v.rw;
      end
    end
    a_req = 1'b0;
    x = sbq.pop_front();
    chk({name, " acked"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'd3);
    if (got) begin
      chk({name, " err"}, 32'(a_err), 32'(x.err));
      if (x.cd) chk({name, " data"}, a_rdata, x.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 3'd0, 32'h013, 32'h0000007F, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 32'h012, 32'h0,        32'hFFFFFFAD, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 3'd4, 32'h013, 32'h0,        32'h0000007F, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 3'd1, 32'h010, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 3'd5, 32'h012, 32'h0,        32'h00007FAD, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 3'd2, 32'h011, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[8]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h7FADBEEF, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 3'd1, 32'h013, 32'h0000AAAA, 32'h0,        1'b1, 1'b1};
    tbl[10] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h7FADBEEF, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 3'd2, 32'h1000, 32'h0,       32'h0,        1'b1, 1'b1};
    tbl[12] = '{1'b1, 3'd2, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    tbl[13] = '{1'b0, 3'd3, 32'h010, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[14] = '{1'b1, 3'd4, 32'h010, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[15] = '{1'b1, 3'd1, 32'h016, 32'h00008234, 32'h0,        1'b0, 1'b0};
    tbl[16] = '{1'b0, 3'd1, 32'h016, 32'h0,        32'hFFFF8234, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h7FADBEEF, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 3'd2, 32'h020, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[19] = '{1'b0, 3'd2, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1};

    rst_n = 1'b0;
    a_req = 1'b0; a_rw = 1'b0; a_f3 = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_rw = 1'b0; b_f3 = '0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset ack", 32'(a_ack), 32'd0);
    chk("reset busy", 32'(a_busy), 32'd0);
    chk("reset err", 32'(a_err), 32'd0);
    chk("reset data", a_rdata, 32'd0);
    chk("reset b ack", 32'(b_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) txn_a(tbl[i], $sformatf("vec%0d", i));

    // Reset while a store is waiting: outputs clear at once, write is dropped.
    @(negedge clk);
    a_req = 1'b1; a_rw = 1'b1; a_f3 = 3'd2; a_addr = 32'h20; a_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    chk("rst wait busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async ack", 32'(a_ack), 32'd0);
    chk("rst async busy", 32'(a_busy), 32'd0);
    chk("rst async err", 32'(a_err), 32'd0);
    chk("rst async data", a_rdata, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn_a('{1'b0, 3'd2, 32'h020, 32'h0, 32'h0, 1'b0, 1'b1}, "rst dropped write");

    // Zero latency, request held through the ack cycle, then a second request.
    b_acks = 0;
    @(negedge clk);
    b_req = 1'b1; b_rw = 1'b1; b_f3 = 3'd2; b_addr = 32'h40; b_wdata = 32'h11112222;
    @(posedge clk);
    @(negedge clk);
    chk("b first ack", 32'(b_ack), 32'd1);
    chk("b first err", 32'(b_err), 32'd0);
    @(negedge clk);
    chk("b no reaccept ack", 32'(b_ack), 32'd0);
    chk("b no reaccept busy", 32'(b_busy), 32'd0);
    b_rw = 1'b0;
    @(negedge clk);
    chk("b second ack", 32'(b_ack), 32'd1);
    chk("b second data", b_rdata, 32'h11112222);
    b_req = 1'b0;
    @(negedge clk);
    chk("b ack drop", 32'(b_ack), 32'd0);
    chk("b ack count", 32'(b_acks), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
